// File: rtl/fencing_pkg.sv
// Shared fencing package: bout FSM states, winner encoding, screen location
// and generic data types, plus the default winning score.
// No ports (package only).
package fencing_pkg;

  // Default number of touches needed to win a match.
  localparam int WIN_SCORE_DEFAULT = 5;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_READY = 3'd1,
    COUNTDOWN  = 3'd2,
    FENCING    = 3'd3,
    TOUCH      = 3'd4,
    MATCH_OVER = 3'd5
  } bout_state_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    PLAYER   = 2'd1,
    OPPONENT = 2'd2,
    DRAW     = 2'd3
  } winner_t;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
  } location_t;

  typedef logic [7:0] data_t;

  // Higher score wins, equal scores are a draw. This covers both the
  // normal WIN_SCORE finish (double touch to WIN_SCORE ties) and the
  // time-limit finish.
  function automatic winner_t decide_winner(input logic [3:0] player,
                                            input logic [3:0] opponent);
    if (player > opponent) begin
      return PLAYER;
    end else if (opponent > player) begin
      return OPPONENT;
    end
    return DRAW;
  endfunction

endpackage

// File: rtl/bout_controller_sec_timer.sv
// sec_timer: per-second prescaler driving a loadable seconds down-counter.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   restart       - reload secs from load_sec and clear the prescaler
//   enable        - prescaler advances only while high
//   load_sec      - seconds value loaded on restart
//   secs          - seconds remaining (counts down, stops at 0)
//   done          - high in the final cycle of the final second
module sec_timer #(
  parameter int CYCLES_PER_SEC = 74_250_000,
  parameter int SEC_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             enable,
  input  logic [SEC_W-1:0] load_sec,
  output logic [SEC_W-1:0] secs,
  output logic             done
);

  localparam int PRE_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_PER_SEC - 1);

  logic [PRE_W-1:0] pre;
  logic             sec_tick;

  assign sec_tick = enable && (secs != '0) && (pre == PRE_LAST);
  // Signalled one cycle early so the owner can change state exactly when
  // the loaded number of seconds has elapsed.
  assign done     = sec_tick && (secs == SEC_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre  <= '0;
      secs <= '0;
    end else if (restart) begin
      pre  <= '0;
      secs <= load_sec;
    end else if (enable && (secs != '0)) begin
      if (sec_tick) begin
        pre  <= '0;
        secs <= secs - 1'b1;
      end else begin
        pre  <= pre + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bout_controller.sv
// bout_controller: match sequencing for a two-board fencing game.
// Optional feature macro: BOUT_TIME_LIMIT_EN (cumulative FENCING time limit).
// Ports:
//   clk_pixel_in, rst_in            - clock, asynchronous active-high reset
//   self_started_in, opponent_started_in - start levels from both boards
//   player_scored_in, opponent_scored_in - touches, qualified by score_valid_in
//   score_valid_in, restart_in      - one-cycle strobes
//   state_out                       - current bout_state_t
//   player_score_out, opponent_score_out - scores
//   countdown_out                   - seconds left in COUNTDOWN, else 0
//   actions_enable_out              - high in FENCING only
//   position_reset_out              - one-cycle pulse on COUNTDOWN entry
//   winner_out                      - winner_t, valid in MATCH_OVER
module bout_controller
  import fencing_pkg::*;
#(
  parameter int CYCLES_PER_SEC = 74_250_000,
  parameter int WIN_SCORE      = WIN_SCORE_DEFAULT,
  parameter int COUNTDOWN_SEC  = 3,
  parameter int TOUCH_HOLD_SEC = 2
`ifdef BOUT_TIME_LIMIT_EN
  ,
  parameter int BOUT_SEC       = 180
`endif
) (
  input  logic       clk_pixel_in,
  input  logic       rst_in,
  input  logic       self_started_in,
  input  logic       opponent_started_in,
  input  logic       player_scored_in,
  input  logic       opponent_scored_in,
  input  logic       score_valid_in,
  input  logic       restart_in,
  output logic [2:0] state_out,
  output logic [3:0] player_score_out,
  output logic [3:0] opponent_score_out,
  output logic [1:0] countdown_out,
  output logic       actions_enable_out,
  output logic       position_reset_out,
  output logic [1:0] winner_out
);

  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  bout_state_t state, state_next;
  logic [3:0]  player_score, player_score_next;
  logic [3:0]  opponent_score, opponent_score_next;
  winner_t     winner, winner_next;
  logic        position_reset, position_reset_next;

  logic        phase_restart;
  logic [7:0]  phase_load;
  logic [7:0]  phase_secs;
  logic        phase_done;

  sec_timer #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC),
    .SEC_W         (8)
  ) phase_timer (
    .clk     (clk_pixel_in),
    .rst     (rst_in),
    .restart (phase_restart),
    .enable  (1'b1),
    .load_sec(phase_load),
    .secs    (phase_secs),
    .done    (phase_done)
  );

`ifdef BOUT_TIME_LIMIT_EN
  logic       bout_restart;
  logic [7:0] bout_secs;
  logic       bout_done;
  logic       bout_time_up;

  // Loaded once per match (IDLE or a restart) and only advanced while
  // FENCING, so it accumulates fencing time across touches.
  assign bout_restart = (state == IDLE) || ((state == MATCH_OVER) && restart_in);
  assign bout_time_up = bout_done && (bout_secs != 8'd0);

  sec_timer #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC),
    .SEC_W         (8)
  ) bout_timer (
    .clk     (clk_pixel_in),
    .rst     (rst_in),
    .restart (bout_restart),
    .enable  (state == FENCING),
    .load_sec(8'(BOUT_SEC)),
    .secs    (bout_secs),
    .done    (bout_done)
  );
`endif

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      player_score   <= 4'd0;
      opponent_score <= 4'd0;
      winner         <= NONE;
      position_reset <= 1'b0;
    end else begin
      state          <= state_next;
      player_score   <= player_score_next;
      opponent_score <= opponent_score_next;
      winner         <= winner_next;
      position_reset <= position_reset_next;
    end
  end

  always_comb begin
    state_next          = state;
    player_score_next   = player_score;
    opponent_score_next = opponent_score;
    winner_next         = winner;
    phase_load          = 8'd0;

    case (state)
      IDLE: state_next = WAIT_READY;
      WAIT_READY: begin
        if (self_started_in && opponent_started_in) begin
          state_next = COUNTDOWN;
        end
      end
      COUNTDOWN: begin
        if (phase_done) begin
          state_next = FENCING;
        end
      end
      FENCING: begin
        if (score_valid_in) begin
          if (player_scored_in && (player_score < WIN)) begin
            player_score_next = player_score + 4'd1;
          end
          if (opponent_scored_in && (opponent_score < WIN)) begin
            opponent_score_next = opponent_score + 4'd1;
          end
          if (player_scored_in || opponent_scored_in) begin
            state_next = TOUCH;
          end
        end
`ifdef BOUT_TIME_LIMIT_EN
        // A same-cycle strobe has already been folded into the next scores.
        if (bout_time_up) begin
          state_next = MATCH_OVER;
        end
`endif
      end
      TOUCH: begin
        if (phase_done) begin
          state_next = ((player_score == WIN) || (opponent_score == WIN)) ?
                       MATCH_OVER : COUNTDOWN;
        end
      end
      MATCH_OVER: begin
        if (restart_in) begin
          state_next          = WAIT_READY;
          player_score_next   = 4'd0;
          opponent_score_next = 4'd0;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next != MATCH_OVER) begin
      winner_next = NONE;
    end else if (state != MATCH_OVER) begin
      winner_next = decide_winner(player_score_next, opponent_score_next);
    end

    // Every state change reloads the phase timer, so no partial second
    // leaks from one phase into the next.
    phase_restart = (state_next != state);
    case (state_next)
      COUNTDOWN: phase_load = 8'(COUNTDOWN_SEC);
      TOUCH:     phase_load = 8'(TOUCH_HOLD_SEC);
      default:   phase_load = 8'd0;
    endcase

    position_reset_next = (state_next == COUNTDOWN) && (state != COUNTDOWN);
  end

  assign state_out          = state;
  assign player_score_out   = player_score;
  assign opponent_score_out = opponent_score;
  assign countdown_out      = (state == COUNTDOWN) ? 2'(phase_secs) : 2'd0;
  assign actions_enable_out = (state == FENCING);
  assign position_reset_out = position_reset;
  assign winner_out         = winner;

endmodule

// File: tb/tb_bout_controller.sv
module tb_bout_controller;

  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_CD = 3'd2,
                         S_FENCE = 3'd3, S_TOUCH = 3'd4, S_OVER = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic self_s = 1'b0, opp_s = 1'b0, ps = 1'b0, os = 1'b0, sv = 1'b0, restart = 1'b0;
  logic [2:0] state;
  logic [3:0] p_sc, o_sc;
  logic [1:0] cd, win;
  logic       ae, pr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bout_controller #(
    .CYCLES_PER_SEC(10),
    .WIN_SCORE     (2),
    .COUNTDOWN_SEC (3),
    .TOUCH_HOLD_SEC(2)
`ifdef BOUT_TIME_LIMIT_EN
    ,
    .BOUT_SEC      (5)
`endif
  ) dut (
    .clk_pixel_in       (clk),
    .rst_in             (rst),
    .self_started_in    (self_s),
    .opponent_started_in(opp_s),
    .player_scored_in   (ps),
    .opponent_scored_in (os),
    .score_valid_in     (sv),
    .restart_in         (restart),
    .state_out          (state),
    .player_score_out   (p_sc),
    .opponent_score_out (o_sc),
    .countdown_out      (cd),
    .actions_enable_out (ae),
    .position_reset_out (pr),
    .winner_out         (win)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic p, input logic o);
    sv = 1'b1; ps = p; os = o;
    tick(1);
    sv = 1'b0; ps = 1'b0; os = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
  endtask

  // Bounded wait; an expired bound counts as a failed comparison.
  task automatic wait_state(input logic [2:0] target, input int bound);
    int n = 0;
    while (state !== target && n < bound) begin
      tick(1);
      n++;
    end
    checks++;
    if (state !== target) begin
      errors++;
      $display("FAIL wait_state: state %0d, expected %0d within %0d cycles", state, target, bound);
    end
  endtask

  task automatic go_fencing();
    self_s = 1'b1; opp_s = 1'b1;
    tick(1);
    self_s = 1'b0; opp_s = 1'b0;
    wait_state(S_FENCE, 40);
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if ({state, p_sc, o_sc, cd, ae, pr, win} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: st=%0d p=%0d o=%0d cd=%0d ae=%0d pr=%0d w=%0d, all must be 0",
               state, p_sc, o_sc, cd, ae, pr, win);
    end
    rst = 1'b0;
    tick(1);
    checks++;
    if (state !== S_WAIT) begin
      errors++; $display("FAIL idle_to_wait: state %0d, expected %0d", state, S_WAIT);
    end
    $display("test_reset done");
  endtask

  task automatic test_countdown();
    self_s = 1'b1;
    tick(2);
    checks++;
    if (state !== S_WAIT) begin
      errors++; $display("FAIL one_side_start: state %0d, expected %0d", state, S_WAIT);
    end
    opp_s = 1'b1;
    tick(1);
    self_s = 1'b0; opp_s = 1'b0;
    checks++;
    if (state !== S_CD || pr !== 1'b1 || cd !== 2'd3) begin
      errors++; $display("FAIL cd_entry: st=%0d pr=%0d cd=%0d, expected st=2 pr=1 cd=3", state, pr, cd);
    end
    for (int k = 1; k < 30; k++) begin
      tick(1);
      checks++;
      if (state !== S_CD || pr !== 1'b0 || cd !== 2'(3 - k / 10)) begin
        errors++;
        $display("FAIL cd_step%0d: st=%0d pr=%0d cd=%0d, expected st=2 pr=0 cd=%0d", k, state, pr, cd, 3 - k / 10);
      end
    end
    tick(1);
    checks++;
    if (state !== S_FENCE || ae !== 1'b1 || cd !== 2'd0) begin
      errors++; $display("FAIL fence_entry: st=%0d ae=%0d cd=%0d, expected st=3 ae=1 cd=0", state, ae, cd);
    end
    $display("test_countdown done");
  endtask

  task automatic test_touch();
    strobe(1'b0, 1'b0);
    checks++;
    if (state !== S_FENCE || p_sc !== 4'd0 || o_sc !== 4'd0) begin
      errors++; $display("FAIL empty_strobe: st=%0d p=%0d o=%0d, expected 3 0 0", state, p_sc, o_sc);
    end
    strobe(1'b1, 1'b0);
    checks++;
    if (state !== S_TOUCH || p_sc !== 4'd1 || o_sc !== 4'd0 || ae !== 1'b0 || win !== 2'd0) begin
      errors++; $display("FAIL player_touch: st=%0d p=%0d o=%0d ae=%0d w=%0d, expected 4 1 0 0 0", state, p_sc, o_sc, ae, win);
    end
    tick(5);
    strobe(1'b1, 1'b1);
    checks++;
    if (state !== S_TOUCH || p_sc !== 4'd1 || o_sc !== 4'd0) begin
      errors++; $display("FAIL strobe_in_touch: st=%0d p=%0d o=%0d, expected 4 1 0", state, p_sc, o_sc);
    end
    tick(13);
    checks++;
    if (state !== S_TOUCH) begin
      errors++; $display("FAIL touch_hold19: state %0d, expected %0d", state, S_TOUCH);
    end
    tick(1);
    checks++;
    if (state !== S_CD || pr !== 1'b1 || cd !== 2'd3) begin
      errors++; $display("FAIL touch_to_cd: st=%0d pr=%0d cd=%0d, expected 2 1 3", state, pr, cd);
    end
    tick(3);
    strobe(1'b0, 1'b1);
    checks++;
    if (state !== S_CD || p_sc !== 4'd1 || o_sc !== 4'd0 || cd !== 2'd3) begin
      errors++; $display("FAIL strobe_in_cd: st=%0d p=%0d o=%0d cd=%0d, expected 2 1 0 3", state, p_sc, o_sc, cd);
    end
    tick(26);
    checks++;
    if (state !== S_FENCE) begin
      errors++; $display("FAIL refence: state %0d, expected %0d", state, S_FENCE);
    end
    pulse_restart();
    checks++;
    if (state !== S_FENCE || p_sc !== 4'd1) begin
      errors++; $display("FAIL restart_in_fence: st=%0d p=%0d, expected 3 1", state, p_sc);
    end
    strobe(1'b1, 1'b0);
    tick(20);
    checks++;
    if (state !== S_OVER || win !== 2'd1 || p_sc !== 4'd2 || o_sc !== 4'd0) begin
      errors++; $display("FAIL player_wins: st=%0d w=%0d p=%0d o=%0d, expected 5 1 2 0", state, win, p_sc, o_sc);
    end
    strobe(1'b0, 1'b1);
    checks++;
    if (state !== S_OVER || o_sc !== 4'd0) begin
      errors++; $display("FAIL strobe_in_over: st=%0d o=%0d, expected 5 0", state, o_sc);
    end
    pulse_restart();
    checks++;
    if (state !== S_WAIT || p_sc !== 4'd0 || o_sc !== 4'd0 || win !== 2'd0) begin
      errors++; $display("FAIL restart_clear: st=%0d p=%0d o=%0d w=%0d, expected 1 0 0 0", state, p_sc, o_sc, win);
    end
    $display("test_touch done");
  endtask

  task automatic test_double();
    go_fencing();
    strobe(1'b1, 1'b1);
    checks++;
    if (state !== S_TOUCH || p_sc !== 4'd1 || o_sc !== 4'd1) begin
      errors++; $display("FAIL double_1_1: st=%0d p=%0d o=%0d, expected 4 1 1", state, p_sc, o_sc);
    end
    tick(20);
    wait_state(S_FENCE, 40);
    strobe(1'b1, 1'b1);
    tick(20);
    checks++;
    if (state !== S_OVER || win !== 2'd3 || p_sc !== 4'd2 || o_sc !== 4'd2) begin
      errors++; $display("FAIL double_draw: st=%0d w=%0d p=%0d o=%0d, expected 5 3 2 2", state, win, p_sc, o_sc);
    end
    pulse_restart();
    checks++;
    if (state !== S_WAIT || p_sc !== 4'd0 || o_sc !== 4'd0 || win !== 2'd0) begin
      errors++; $display("FAIL draw_restart: st=%0d p=%0d o=%0d w=%0d, expected 1 0 0 0", state, p_sc, o_sc, win);
    end
    $display("test_double done");
  endtask

  task automatic test_async_reset();
    go_fencing();
    strobe(1'b1, 1'b0);
    tick(3);
    #3;
    rst = 1'b1; sv = 1'b1; ps = 1'b1;
    #1;
    checks++;
    if ({state, p_sc, o_sc, cd, ae, pr, win} !== 17'd0) begin
      errors++;
      $display("FAIL async_reset: st=%0d p=%0d o=%0d cd=%0d ae=%0d pr=%0d w=%0d, all must be 0",
               state, p_sc, o_sc, cd, ae, pr, win);
    end
    tick(1);
    checks++;
    if ({state, p_sc, o_sc} !== 11'd0) begin
      errors++; $display("FAIL reset_with_strobe: st=%0d p=%0d o=%0d, expected 0 0 0", state, p_sc, o_sc);
    end
    sv = 1'b0; ps = 1'b0;
    rst = 1'b0;
    tick(1);
    checks++;
    if (state !== S_WAIT) begin
      errors++; $display("FAIL post_reset_wait: state %0d, expected %0d", state, S_WAIT);
    end
    $display("test_async_reset done");
  endtask

`ifdef BOUT_TIME_LIMIT_EN
  task automatic test_time_limit();
    go_fencing();
    strobe(1'b1, 1'b0);
    tick(20);
    wait_state(S_FENCE, 40);
    tick(48);
    checks++;
    if (state !== S_FENCE) begin
      errors++; $display("FAIL limit_not_yet: state %0d, expected %0d", state, S_FENCE);
    end
    tick(1);
    checks++;
    if (state !== S_OVER || win !== 2'd1) begin
      errors++; $display("FAIL limit_player: st=%0d w=%0d, expected 5 1", state, win);
    end
    pulse_restart();
    go_fencing();
    tick(49);
    checks++;
    if (state !== S_FENCE) begin
      errors++; $display("FAIL limit0_not_yet: state %0d, expected %0d", state, S_FENCE);
    end
    tick(1);
    checks++;
    if (state !== S_OVER || win !== 2'd3) begin
      errors++; $display("FAIL limit_draw: st=%0d w=%0d, expected 5 3", state, win);
    end
    pulse_restart();
    go_fencing();
    tick(49);
    strobe(1'b0, 1'b1);
    checks++;
    if (state !== S_OVER || o_sc !== 4'd1 || win !== 2'd2) begin
      errors++; $display("FAIL limit_with_strobe: st=%0d o=%0d w=%0d, expected 5 1 2", state, o_sc, win);
    end
    $display("test_time_limit done");
  endtask
`endif

  initial begin
    test_reset();
    test_countdown();
    test_touch();
    test_double();
    test_async_reset();
`ifdef BOUT_TIME_LIMIT_EN
    test_time_limit();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bout_controller.md
BOUT_CONTROLLER -- requirements
Module: bout_controller

Interface
REQ-001 Parameter CYCLES_PER_SEC, default 74_250_000, gives clk_pixel_in cycles per second.
REQ-002 Parameter WIN_SCORE, default 5, is the touches needed to win (range 1..15).
REQ-003 Parameter COUNTDOWN_SEC, default 3, is the en-garde countdown length in seconds (range 1..3).
REQ-004 Parameter TOUCH_HOLD_SEC, default 2, is the freeze time after a touch, in seconds.
REQ-005 clk_pixel_in  in  1  is the single clock.
REQ-006 rst_in  in  1  is an asynchronous, active-high reset.
REQ-007 self_started_in  in  1  is a level: the local player pressed start.
REQ-008 opponent_started_in  in  1  is a level: the remote board reported start.
REQ-009 player_scored_in  in  1  marks a local touch, qualified by score_valid_in.
REQ-010 opponent_scored_in  in  1  marks a remote touch, qualified by score_valid_in.
REQ-011 score_valid_in  in  1  is a one-cycle strobe qualifying both scored inputs.
REQ-012 restart_in  in  1  is a one-cycle strobe requesting a new match from MATCH_OVER.
REQ-013 state_out  out  3  carries the current bout_state_t.
REQ-014 player_score_out  out  4  is the local score.
REQ-015 opponent_score_out  out  4  is the remote score.
REQ-016 countdown_out  out  2  gives the seconds remaining in COUNTDOWN, and is 0 in every other state.
REQ-017 actions_enable_out  out  1  is high only in FENCING and gates IR block/lunge/release handling.
REQ-018 position_reset_out  out  1  is a one-cycle pulse that returns both fencers to their start locations.
REQ-019 winner_out  out  2  carries winner_t: NONE=0, PLAYER=1, OPPONENT=2, DRAW=3.

Function
REQ-020 The block SHALL implement the states IDLE, WAIT_READY, COUNTDOWN, FENCING, TOUCH and MATCH_OVER.
REQ-021 IDLE SHALL move to WAIT_READY unconditionally on the cycle after reset deasserts.
REQ-022 WAIT_READY SHALL move to COUNTDOWN in the cycle when self_started_in and opponent_started_in are both high.
REQ-023 COUNTDOWN SHALL last exactly COUNTDOWN_SEC*CYCLES_PER_SEC cycles, with countdown_out stepping COUNTDOWN_SEC..1, then move to FENCING.
REQ-024 FENCING SHALL move to TOUCH on score_valid_in when at least one scored input is high; a strobe with both scored inputs low SHALL be ignored.
REQ-025 Score counters SHALL update one cycle after the qualifying strobe, and each SHALL saturate at WIN_SCORE.
REQ-026 When both scored inputs are high on the same strobe (double touch), both scores SHALL increment.
REQ-027 score_valid_in SHALL be ignored in every state other than FENCING.
REQ-028 TOUCH SHALL hold for TOUCH_HOLD_SEC*CYCLES_PER_SEC cycles and then go to MATCH_OVER if any score equals WIN_SCORE, otherwise to COUNTDOWN.
REQ-029 winner_out SHALL be latched on entry to MATCH_OVER: PLAYER or OPPONENT for the side at WIN_SCORE, DRAW if both sides reach it; it SHALL read NONE elsewhere.
REQ-030 position_reset_out SHALL pulse for exactly one cycle on every entry to COUNTDOWN.
REQ-031 MATCH_OVER SHALL, on restart_in, clear both scores and winner_out and go to WAIT_READY; restart_in SHALL be ignored in all other states.
REQ-032 The second timer SHALL restart from zero on every state entry, so no partial second carries over between states.

Reset
REQ-033 While rst_in is high, the block SHALL be in IDLE with both scores 0, countdown_out 0, actions_enable_out 0, position_reset_out 0, winner_out NONE, and all timers 0.
REQ-034 Reset asserted mid-FENCING or mid-TOUCH SHALL abort the bout immediately (asynchronously), with no score update from a strobe in the same cycle.

Configuration
REQ-035 The macro BOUT_TIME_LIMIT_EN SHALL control the bout time limit.
REQ-036 With BOUT_TIME_LIMIT_EN defined, a parameter BOUT_SEC (default 180) SHALL bound the cumulative time spent in FENCING across one match.
REQ-037 With BOUT_TIME_LIMIT_EN defined, expiry in FENCING SHALL go directly to MATCH_OVER with the higher score winning, or DRAW if equal.
REQ-038 With BOUT_TIME_LIMIT_EN defined, a score strobe in the same cycle as expiry SHALL be applied first.
REQ-039 Without BOUT_TIME_LIMIT_EN, a match SHALL end only on score, and no limit counter SHALL exist.

Structure
REQ-040 The typedefs bout_state_t and winner_t SHALL live in the shared fencing package alongside location_t and data_t.
REQ-041 The WIN_SCORE default SHALL live in that same package.
REQ-042 One sub-module, sec_timer, SHALL provide a per-second tick prescaler, a loadable seconds down-counter, a done flag and a restart input.
REQ-043 The top level SHALL instantiate sec_timer twice: once for phase timing, and once for the bout limit when BOUT_TIME_LIMIT_EN is defined.

Verification (CYCLES_PER_SEC=10, WIN_SCORE=2, COUNTDOWN_SEC=3, TOUCH_HOLD_SEC=2, BOUT_SEC=5)
REQ-044 Both started inputs high -> position_reset_out pulses once -> countdown_out reads 3,2,1 for 10 cycles each -> FENCING on cycle 30 with actions_enable_out=1.
REQ-045 Strobe with player_scored_in=1 in FENCING -> player_score_out=1 next cycle -> 20 cycles in TOUCH -> COUNTDOWN; a second player touch -> MATCH_OVER with winner_out=1.
REQ-046 Double touch at 1-1 -> scores 2-2 -> MATCH_OVER with winner_out=3; restart_in then clears the scores and enters WAIT_READY.
REQ-047 Strobes in COUNTDOWN and TOUCH, and restart_in in FENCING -> no score or state change.
REQ-048 rst_in asserted mid-TOUCH at score 1-0 -> all outputs return to reset values asynchronously.
REQ-049 BOUT_TIME_LIMIT_EN with score 1-0 and 50 FENCING cycles elapsed -> MATCH_OVER with winner_out=1; at 0-0 -> winner_out=3.
